// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder_share_arb block.
// Holds the default NREQ/W sizing, the round-robin pick function and
// the stage-1 pipeline record. The record and rr_pick are sized by the
// localparams below, so a different NREQ/W is configured here.
package adder_share_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 8;
    localparam int unsigned IDW_DEF  = $clog2(NREQ_DEF);

    // Stage-1 record: winning operands, resolved carry-in and owner index.
    typedef struct packed {
        logic               valid;
        logic [IDW_DEF-1:0] id;
        logic [W_DEF-1:0]   a;
        logic [W_DEF-1:0]   b;
        logic               carry;
    } s1_rec_t;

    // One-hot grant: first requester with req high, scanning ptr, ptr+1, ... mod NREQ.
    function automatic logic [NREQ_DEF-1:0] rr_pick(
        input logic [NREQ_DEF-1:0] req,
        input logic [IDW_DEF-1:0]  ptr
    );
        logic [NREQ_DEF-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ_DEF; i++) begin
            idx = (32'(ptr) + i) % NREQ_DEF;
            if (!found && req[IDW_DEF'(idx)]) begin
                pick[IDW_DEF'(idx)] = 1'b1;
                found               = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus the priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request
//   accept     : a transfer happened this cycle (from the top level)
//   acc_id     : index of the accepted requester
//   gnt        : one-hot pick from req and the current pointer (combinational)
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    accept,
    input  logic [$clog2(NREQ)-1:0] acc_id,
    output logic [NREQ-1:0]         gnt
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;

    assign gnt = rr_pick(req, ptr);

    // After serving index k, k+1 (mod NREQ) becomes highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (acc_id == IDW'(NREQ - 1)) ? '0 : acc_id + IDW'(1);
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one registered W-bit adder among NREQ requesters.
// A round-robin arbiter picks a requester, stage 1 registers its operands
// and carry-in, stage 2 registers {cout, sum} tagged with the owner index.
// Optional lock/carry-chain mode: define ADDER_SHARE_ARB_LOCK_EN.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req, chain, cin : per-requester request, more-beats-follow, carry-in
//   a_in, b_in      : operands, requester i in bits [i*W +: W]
//   gnt             : one-hot grant (combinational)
//   rsp_valid       : one-cycle result pulse per accepted request
//   rsp_id, sum,cout: owner index and registered result
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         chain,
    input  logic [NREQ*W-1:0]       a_in,
    input  logic [NREQ*W-1:0]       b_in,
    input  logic [NREQ-1:0]         cin,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            sum,
    output logic                    cout
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0] arb_gnt;
    logic            accept;
    logic [IDW-1:0]  acc_id;
    logic            carry_sel;
    s1_rec_t         s1;
    logic [W:0]      s1_full;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .acc_id (acc_id),
        .gnt    (arb_gnt)
    );

    // Single adder; feeds stage 2 and, in lock mode, the forwarded chain carry.
    assign s1_full = (W+1)'(s1.a) + (W+1)'(s1.b) + (W+1)'(s1.carry);

`ifdef ADDER_SHARE_ARB_LOCK_EN
    logic           lock;
    logic [IDW-1:0] lock_id;
    logic           chain_c;

    // S1 operands hold between acceptances and nobody else is served while
    // locked, so they always belong to lock_id's previous beat.
    assign chain_c = s1_full[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (accept) begin
            lock    <= chain[acc_id];
            lock_id <= acc_id;
        end
    end

    // Lock forces the grant to its owner even when it is not requesting.
    always_comb begin
        gnt = arb_gnt;
        if (lock) begin
            gnt          = '0;
            gnt[lock_id] = 1'b1;
        end
        if (!rst_n) begin
            gnt = '0;
        end
    end

    always_comb begin
        carry_sel = cin[acc_id];
        if (lock) begin
            carry_sel = chain_c;
        end
    end
`else
    logic chain_unused;
    assign chain_unused = ^chain;

    always_comb begin
        gnt = arb_gnt;
        if (!rst_n) begin
            gnt = '0;
        end
    end

    assign carry_sel = cin[acc_id];
`endif

    // Encode the one-hot grant into the accepted index.
    always_comb begin
        acc_id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                acc_id = IDW'(i);
            end
        end
    end

    assign accept = |(req & gnt);

    // Stage 1: capture the winner; data holds when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1.valid <= accept;
            if (accept) begin
                s1.id    <= acc_id;
                s1.a     <= a_in[32'(acc_id)*W +: W];
                s1.b     <= b_in[32'(acc_id)*W +: W];
                s1.carry <= carry_sel;
            end
        end
    end

    // Stage 2: registered result; holds when stage 1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            rsp_valid <= s1.valid;
            if (s1.valid) begin
                {cout, sum} <= s1_full;
                rsp_id      <= s1.id;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (NREQ=4, W=8).
// Lock-chain expectations follow ADDER_SHARE_ARB_LOCK_EN.
module tb_adder_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  chain;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  cin;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  sum;
    logic        cout;

    int n_asrt = 0;
    int n_fail = 0;

    adder_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .chain     (chain),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {rsp_valid, rsp_id, cout, sum} as one value.
    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic co, input logic [7:0] s);
        chk(tag, {20'd0, rsp_valid, rsp_id, cout, sum}, {20'd0, v, id, co, s});
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
        cin[i]         = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        chain = '0;
        cin   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        req   = '0;
        chain = '0;
        cin   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk_rsp("rst_out", 1'b0, 2'd0, 1'b0, 8'h00);
        rst_n = 1'b1;

        // Reset mid-pipeline discards the in-flight op
        set_op(0, 8'h10, 8'h20, 1'b0);
        req = 4'b0001;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt_low", 32'(gnt), 32'h0);
        chk_rsp("midrst_out_during", 1'b0, 2'd0, 1'b0, 8'h00);
        tick();
        chk_rsp("midrst_out_during2", 1'b0, 2'd0, 1'b0, 8'h00);
        req   = '0;
        rst_n = 1'b1;
        tick();
        chk_rsp("midrst_after1", 1'b0, 2'd0, 1'b0, 8'h00);
        tick();
        chk_rsp("midrst_after2", 1'b0, 2'd0, 1'b0, 8'h00);

        // Single requester: FF + 01 + 1 = 0x101
        set_op(2, 8'hFF, 8'h01, 1'b1);
        req = 4'b0100;
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        chk("single_lat1", 32'(rsp_valid), 32'h0);
        tick();
        chk_rsp("single_rsp", 1'b1, 2'd2, 1'b1, 8'h01);
        tick();
        chk_rsp("single_hold", 1'b0, 2'd2, 1'b1, 8'h01);

        // Fairness with all four requesting
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_gnt", 32'(gnt), 32'd1 << (c % 4));
            if (c >= 2) begin
                chk_rsp("fair_rsp", 1'b1, 2'((c - 2) % 4), 1'b0, 8'h00);
            end else begin
                chk("fair_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            tick();
        end
        req = '0;

        // Sparse requests 1,3,1,3 then requester 0
        do_reset();
        set_op(1, 8'h3C, 8'h0F, 1'b0);  // 4B, cout 0
        set_op(3, 8'hF0, 8'h20, 1'b1);  // 111 -> 11, cout 1
        set_op(0, 8'h80, 8'h80, 1'b1);  // 101 -> 01, cout 1
        req = 4'b1010;
        #1;
        chk("sparse_g0", 32'(gnt), 32'h2);
        chk("sparse_r0", 32'(rsp_valid), 32'h0);
        tick();
        chk("sparse_g1", 32'(gnt), 32'h8);
        chk("sparse_r1", 32'(rsp_valid), 32'h0);
        tick();
        chk("sparse_g2", 32'(gnt), 32'h2);
        chk_rsp("sparse_r2", 1'b1, 2'd1, 1'b0, 8'h4B);
        tick();
        chk("sparse_g3", 32'(gnt), 32'h8);
        chk_rsp("sparse_r3", 1'b1, 2'd3, 1'b1, 8'h11);
        tick();
        req = 4'b1011;
        #1;
        chk("sparse_g4", 32'(gnt), 32'h1);
        chk_rsp("sparse_r4", 1'b1, 2'd1, 1'b0, 8'h4B);
        tick();
        req = '0;
        #1;
        chk("sparse_g5", 32'(gnt), 32'h0);
        chk_rsp("sparse_r5", 1'b1, 2'd3, 1'b1, 8'h11);
        tick();
        chk_rsp("sparse_r6", 1'b1, 2'd0, 1'b1, 8'h01);
        tick();
        chk("sparse_r7", 32'(rsp_valid), 32'h0);

        // Request withdrawn in its grant cycle: no transfer, pointer holds
        do_reset();
        req = 4'b0010;
        #1;
        chk("drop_gnt", 32'(gnt), 32'h2);
        req = '0;
        #1;
        tick();
        tick();
        chk("drop_no_rsp", 32'(rsp_valid), 32'h0);
        req = 4'b0101;
        #1;
        chk("drop_ptr_hold", 32'(gnt), 32'h1);
        req = '0;

        // Two-beat chain from requester 1 with requester 0 competing
        do_reset();
        set_op(0, 8'h05, 8'h06, 1'b0);  // 0B
        req = 4'b0001;
        #1;
        chk("chain_pre_gnt", 32'(gnt), 32'h1);
        tick();
        set_op(1, 8'hFF, 8'h01, 1'b0);
        chain = 4'b0010;
        req   = 4'b0011;
        #1;
        chk("chain_beat1_gnt", 32'(gnt), 32'h2);
        tick();
        set_op(1, 8'h01, 8'h00, 1'b0);
        chain = 4'b0000;
`ifdef ADDER_SHARE_ARB_LOCK_EN
        #1;
        chk("lock_stall_gnt", 32'(gnt), 32'h2);
        chk_rsp("lock_rsp0", 1'b1, 2'd0, 1'b0, 8'h0B);
        tick();
        req = 4'b0001;
        #1;
        chk("lock_release_gnt", 32'(gnt), 32'h1);
        chk_rsp("lock_beat1", 1'b1, 2'd1, 1'b1, 8'h00);
        tick();
        req = '0;
        #1;
        chk_rsp("lock_beat2", 1'b1, 2'd1, 1'b0, 8'h02);
        tick();
        chk_rsp("lock_rsp0b", 1'b1, 2'd0, 1'b0, 8'h0B);
`else
        #1;
        chk("nolock_gnt0", 32'(gnt), 32'h1);
        chk_rsp("nolock_rsp0", 1'b1, 2'd0, 1'b0, 8'h0B);
        tick();
        req = 4'b0010;
        #1;
        chk("nolock_gnt1", 32'(gnt), 32'h2);
        chk_rsp("nolock_beat1", 1'b1, 2'd1, 1'b1, 8'h00);
        tick();
        req = '0;
        #1;
        chk_rsp("nolock_rsp0b", 1'b1, 2'd0, 1'b0, 8'h0B);
        tick();
        chk_rsp("nolock_beat2", 1'b1, 2'd1, 1'b0, 8'h01);
`endif
        tick();
        chk("final_idle", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
